// File: rtl/clint_arb_pkg.sv
// Shared definitions for the CLINT request arbiter: FSM encoding and the
// standard CLINT register offsets used by benches and address decoders.
package clint_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  localparam logic [15:0] MSIP_BASE     = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] MTIME_BASE    = 16'hBFF8;

endpackage

// File: rtl/clint_arbiter_rr_pick.sv
// Round-robin pick: returns the first asserted request at or after ptr,
// wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             any_req
);

  int unsigned idx;

  // Scan offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    grant   = '0;
    any_req = |req;
    idx     = 0;
    for (int unsigned off = N_REQ; off > 0; off--) begin
      idx = 32'(ptr) + off - 1;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[IDX_W'(idx)]) grant = IDX_W'(idx);
    end
  end

endmodule

// File: rtl/clint_arbiter.sv
// Round-robin arbiter funnelling N_REQ requesters onto one CLINT port,
// one transaction in flight, with a response timeout that flags err.
module clint_arbiter
  import clint_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_address,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  input  logic [N_REQ*DATA_W/8-1:0] req_wstrb,
  output logic [DATA_W-1:0]       req_rdata,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    m_valid,
  output logic [ADDR_W-1:0]       m_address,
  output logic [DATA_W-1:0]       m_wdata,
  output logic [DATA_W/8-1:0]     m_wstrb,
  input  logic [DATA_W-1:0]       m_rdata,
  input  logic                    m_ready,
  output logic                    err
);

  localparam int          IDX_W   = $clog2(N_REQ);
  localparam int          STRB_W  = DATA_W / 8;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr, grant, grant_q, next_ptr;
  logic               any_req;
  logic [15:0]        wait_cnt;
  logic               take, respond, timeout;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [STRB_W-1:0]  sel_wstrb;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .grant   (grant),
    .any_req (any_req)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant == IDX_W'(i)) begin
        sel_addr  = req_address[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_wstrb = req_wstrb[i*STRB_W +: STRB_W];
      end
    end
  end

  assign next_ptr = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
  assign m_valid  = (state_q == ST_ISSUE);

  // A response in the same cycle as the timeout wins, so err stays low.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    respond = 1'b0;
    timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          take    = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (m_ready) begin
          respond = 1'b1;
          state_d = ST_IDLE;
        end else if (wait_cnt == TO_LAST) begin
          timeout = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr    <= '0;
      grant_q   <= '0;
      wait_cnt  <= '0;
      req_ready <= '0;
      req_rdata <= '0;
      err       <= 1'b0;
      m_address <= '0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
    end else begin
      req_ready <= '0;
      err       <= 1'b0;
      if (take) begin
        grant_q   <= grant;
        m_address <= sel_addr;
        m_wdata   <= sel_wdata;
        m_wstrb   <= sel_wstrb;
      end
      if (state_q == ST_ISSUE) begin
        wait_cnt <= '0;
      end else if (state_q == ST_WAIT && !m_ready) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
      if (respond || timeout) begin
        req_ready <= N_REQ'(1) << grant_q;
        req_rdata <= respond ? m_rdata : '0;
        err       <= timeout;
        rr_ptr    <= next_ptr;
      end
    end
  end

endmodule

// File: tb/tb_clint_arbiter.sv
// Directed bench for clint_arbiter: vector table of single transactions
// plus hand sequences for fairness, timeout, reset and spurious responses.
module tb_clint_arbiter;
  import clint_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [63:0] req_address;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic [31:0] req_rdata;
  logic [1:0]  req_ready;
  logic        m_valid;
  logic [31:0] m_address;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  clint_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .N_REQ   (2),
    .TIMEOUT (15)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_address (req_address),
    .req_wdata   (req_wdata),
    .req_wstrb   (req_wstrb),
    .req_rdata   (req_rdata),
    .req_ready   (req_ready),
    .m_valid     (m_valid),
    .m_address   (m_address),
    .m_wdata     (m_wdata),
    .m_wstrb     (m_wstrb),
    .m_rdata     (m_rdata),
    .m_ready     (m_ready),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          r;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] resp;
    logic [1:0]  exp_ready;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int r, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    req_valid[r]          = 1'b1;
    req_address[r*32 +: 32] = a;
    req_wdata[r*32 +: 32]   = d;
    req_wstrb[r*4 +: 4]     = s;
  endtask

  // Uncontended transaction from IDLE; called just after a clock edge.
  task automatic do_txn(input vec_t v);
    drive_req(v.r, v.addr, v.wdata, v.wstrb);
    step();
    check("issue_m_valid", 32'(m_valid), 32'd1);
    check("issue_m_address", m_address, v.addr);
    check("issue_m_wdata", m_wdata, v.wdata);
    check("issue_m_wstrb", 32'(m_wstrb), 32'(v.wstrb));
    step();
    check("wait_m_valid", 32'(m_valid), 32'd0);
    m_ready = 1'b1;
    m_rdata = v.resp;
    step();
    m_ready = 1'b0;
    req_valid[v.r] = 1'b0;
    check("resp_req_ready", 32'(req_ready), 32'(v.exp_ready));
    check("resp_req_rdata", req_rdata, v.exp_rdata);
    check("resp_err", 32'(err), 32'd0);
    step();
    check("resp_pulse_end", 32'(req_ready), 32'd0);
  endtask

  initial begin
    int          bad;
    logic [31:0] held;
    vec_t        v;

    vecs[0] = '{r: 0, addr: 32'(MTIMECMP_BASE), wdata: 32'h10, wstrb: 4'hF,
                resp: 32'h0, exp_ready: 2'b01, exp_rdata: 32'h0};
    vecs[1] = '{r: 1, addr: 32'(MTIME_BASE), wdata: 32'h0, wstrb: 4'h0,
                resp: 32'h12345678, exp_ready: 2'b10, exp_rdata: 32'h12345678};
    vecs[2] = '{r: 1, addr: 32'h4, wdata: 32'hDEADBEEF, wstrb: 4'hF,
                resp: 32'hAAAA5555, exp_ready: 2'b10, exp_rdata: 32'hAAAA5555};
    vecs[3] = '{r: 0, addr: 32'(MSIP_BASE), wdata: 32'h0, wstrb: 4'h3,
                resp: 32'h1, exp_ready: 2'b01, exp_rdata: 32'h1};

    reset = 1'b1; req_valid = '0; req_address = '0; req_wdata = '0; req_wstrb = '0;
    m_rdata = '0; m_ready = 1'b0;
    step(); step();
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_req_rdata", req_rdata, 32'd0);
    check("reset_m_valid", 32'(m_valid), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 4; i++) do_txn(vecs[i]);

    // Fairness: both requesters hold valid, CLINT answers immediately.
    reset = 1'b1; step(); reset = 1'b0; step();
    m_ready = 1'b1;
    m_rdata = 32'h5A5A5A5A;
    drive_req(0, 32'h100, 32'h0, 4'h0);
    drive_req(1, 32'h200, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("rr_m_valid", 32'(m_valid), 32'd1);
      check("rr_m_address", m_address, (k % 2 == 0) ? 32'h100 : 32'h200);
      step();
      step();
      check("rr_req_ready", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k == 3) begin
        req_valid = '0;
        m_ready = 1'b0;
      end
    end
    step();

    // Timeout: no m_ready, response must land after 15 WAIT cycles.
    drive_req(0, 32'h8000, 32'h0, 4'h0);
    step();
    check("to_m_valid", 32'(m_valid), 32'd1);
    bad = 0;
    for (int e = 1; e <= 15; e++) begin
      step();
      if (req_ready != 2'b00 || err != 1'b0) bad++;
    end
    check("to_early_resp", 32'(bad), 32'd0);
    step();
    req_valid = '0;
    check("to_req_ready", 32'(req_ready), 32'd1);
    check("to_err", 32'(err), 32'd1);
    check("to_rdata", req_rdata, 32'd0);
    step();
    check("to_err_pulse", 32'(err), 32'd0);
    v = '{r: 1, addr: 32'(MTIME_BASE), wdata: 32'h0, wstrb: 4'h0,
          resp: 32'h0BADF00D, exp_ready: 2'b10, exp_rdata: 32'h0BADF00D};
    do_txn(v);

    // m_ready on the timeout cycle counts as a normal response.
    drive_req(0, 32'h8000, 32'h0, 4'h0);
    step();
    for (int e = 1; e <= 15; e++) step();
    m_ready = 1'b1;
    m_rdata = 32'h77;
    step();
    m_ready = 1'b0;
    req_valid = '0;
    check("tie_req_ready", 32'(req_ready), 32'd1);
    check("tie_err", 32'(err), 32'd0);
    check("tie_rdata", req_rdata, 32'h77);
    step();

    // Reset mid-WAIT with rr_ptr pointing at requester 1.
    v = '{r: 0, addr: 32'h0, wdata: 32'h0, wstrb: 4'h0,
          resp: 32'hCAFE0001, exp_ready: 2'b01, exp_rdata: 32'hCAFE0001};
    do_txn(v);
    drive_req(0, 32'h4008, 32'h0, 4'h0);
    step();
    step();
    reset = 1'b1;
    req_valid = '0;
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_req_rdata", req_rdata, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_m_address", m_address, 32'd0);
    step();
    reset = 1'b0;
    drive_req(0, 32'h300, 32'h0, 4'h0);
    drive_req(1, 32'h400, 32'h0, 4'h0);
    step();
    check("rst_grant0", m_address, 32'h300);
    step();
    m_ready = 1'b1;
    m_rdata = 32'h3;
    step();
    m_ready = 1'b0;
    req_valid = '0;
    check("rst_resp_ready", 32'(req_ready), 32'd1);
    step();

    // Spurious m_ready while IDLE.
    held = req_rdata;
    m_ready = 1'b1;
    m_rdata = 32'hFFFFFFFF;
    bad = 0;
    for (int e = 0; e < 3; e++) begin
      step();
      if (req_ready != 2'b00 || m_valid != 1'b0 || err != 1'b0) bad++;
    end
    m_ready = 1'b0;
    check("spur_no_resp", 32'(bad), 32'd0);
    check("spur_rdata_hold", req_rdata, held);
    v = '{r: 1, addr: 32'(MSIP_BASE) + 32'h4, wdata: 32'h1, wstrb: 4'hF,
          resp: 32'h0, exp_ready: 2'b10, exp_rdata: 32'h0};
    do_txn(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
